// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - shared input-path types and default timing constants
package button_event_decoder_pkg;

    // Button FSM states shared by the input-path blocks
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_state_e;

    // Default durations, counted in game ticks
    localparam int DEFAULT_HOLD_TICKS   = 32;
    localparam int DEFAULT_REPEAT_TICKS = 8;
    localparam int DEFAULT_CNT_W        = 6;

endpackage

// File: rtl/button_event_decoder_if.sv
// rtl/button_event_decoder_if.sv - button level/tick inputs and decoded event outputs
interface button_event_decoder_if;

    logic tick_en;
    logic btn_level;
    logic press;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;
    logic held;

    // Driver side: supplies level and tick, observes events
    modport master (
        output tick_en,
        output btn_level,
        input  press,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse,
        input  held
    );

    // Decoder side: consumes level and tick, produces events
    modport slave (
        input  tick_en,
        input  btn_level,
        output press,
        output release_pulse,
        output long_press,
        output repeat_pulse,
        output held
    );

endinterface

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into press/release/long/repeat events
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int HOLD_TICKS   = DEFAULT_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    button_event_decoder_if.slave  bus
);

    // Terminal counts: the counter is compared against N-1 so it never wraps
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    btn_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             press_q, release_q, long_q, repeat_q, held_q;
    logic             press_next, release_next, long_next, repeat_next;

    // Next state, next count and event pulses; release takes priority over a tick
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.btn_level) begin
                    state_next = ST_PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!bus.btn_level) begin
                    state_next   = ST_IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else if (bus.tick_en) begin
                    if (cnt == HOLD_LAST) begin
                        state_next = ST_LONG;
                        cnt_next   = '0;
                        long_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            ST_LONG: begin
                if (!bus.btn_level) begin
                    state_next   = ST_IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else if (bus.tick_en) begin
                    if (cnt == REPEAT_LAST) begin
                        cnt_next    = '0;
                        repeat_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, tick counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            press_q   <= press_next;
            release_q <= release_next;
            long_q    <= long_next;
            repeat_q  <= repeat_next;
            held_q    <= (state_next != ST_IDLE);
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_press    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed self-checking bench for button_event_decoder
module tb_button_event_decoder;

    // Output vector order: {press, release, long_press, repeat_pulse, held}
    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_HELD  = 5'b00001;
    localparam logic [4:0] E_PRESS = 5'b10001;
    localparam logic [4:0] E_REL   = 5'b01000;
    localparam logic [4:0] E_LONG  = 5'b00101;
    localparam logic [4:0] E_REP   = 5'b00011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .HOLD_TICKS   (4),
        .REPEAT_TICKS (2),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {bus.press, bus.release_pulse, bus.long_press, bus.repeat_pulse, bus.held};
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply inputs for one clock edge, then settle just after it
    task automatic cyc(input logic btn, input logic tick);
        bus.btn_level = btn;
        bus.tick_en   = tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.btn_level = 1'b0;
        bus.tick_en   = 1'b0;

        // Reset held low, button toggling: nothing may come out
        cyc(1'b0, 1'b0);
        check("reset_idle", outs(), E_NONE);
        for (int i = 0; i < 4; i++) begin
            cyc(i[0] == 1'b0, 1'b1);
            check($sformatf("reset_toggle%0d", i), outs(), E_NONE);
        end
        bus.btn_level = 1'b0;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        check("post_reset_idle", outs(), E_NONE);
        cyc(1'b0, 1'b1);
        check("idle_tick_ignored", outs(), E_NONE);

        // Short tap, five cycles high, no ticks
        cyc(1'b1, 1'b0);
        check("tap_press", outs(), E_PRESS);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0);
            check("tap_hold", outs(), E_HELD);
        end
        cyc(1'b0, 1'b0);
        check("tap_release", outs(), E_REL);
        cyc(1'b0, 1'b0);
        check("tap_idle", outs(), E_NONE);

        // Long hold: tick on the press edge is ignored, then 10 ticks every 3 cycles
        cyc(1'b1, 1'b1);
        check("hold_press", outs(), E_PRESS);
        begin
            int k;
            logic [4:0] exp;
            k = 0;
            for (int i = 0; i < 30; i++) begin
                if (i % 3 == 2) begin
                    k++;
                    cyc(1'b1, 1'b1);
                    if (k == 4)                     exp = E_LONG;
                    else if (k == 6 || k == 8 || k == 10) exp = E_REP;
                    else                            exp = E_HELD;
                end else begin
                    cyc(1'b1, 1'b0);
                    exp = E_HELD;
                end
                check($sformatf("hold_c%0d_t%0d", i, k), outs(), exp);
            end
        end
        cyc(1'b0, 1'b1);
        check("hold_release", outs(), E_REL);
        cyc(1'b0, 1'b0);
        check("hold_idle", outs(), E_NONE);

        // Fall coincides with the 4th tick: release wins
        cyc(1'b1, 1'b0);
        check("race_press", outs(), E_PRESS);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            check("race_tick", outs(), E_HELD);
        end
        cyc(1'b0, 1'b1);
        check("race_release_only", outs(), E_REL);
        cyc(1'b0, 1'b1);
        check("race_idle", outs(), E_NONE);

        // Reset pulse mid-LONG with the button still down
        cyc(1'b1, 1'b0);
        check("rst_mid_press", outs(), E_PRESS);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        check("rst_mid_long", outs(), E_LONG);
        cyc(1'b1, 1'b1);
        check("rst_mid_inlong", outs(), E_HELD);
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", outs(), E_NONE);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0);
        check("rst_fresh_press", outs(), E_PRESS);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            check("rst_recount", outs(), E_HELD);
        end
        cyc(1'b1, 1'b1);
        check("rst_long_again", outs(), E_LONG);

        // Back-to-back release and re-press; counter restarts from zero
        cyc(1'b0, 1'b0);
        check("b2b_release", outs(), E_REL);
        cyc(1'b1, 1'b0);
        check("b2b_press", outs(), E_PRESS);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            check("b2b_recount", outs(), E_HELD);
        end
        cyc(1'b1, 1'b1);
        check("b2b_long", outs(), E_LONG);
        cyc(1'b1, 1'b1);
        check("b2b_rep_wait", outs(), E_HELD);
        cyc(1'b1, 1'b1);
        check("b2b_repeat", outs(), E_REP);
        cyc(1'b0, 1'b0);
        check("b2b_final_release", outs(), E_REL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, stretched button level produced by the front-end debouncer and turns it into discrete game events: single-cycle press, release, long-press and auto-repeat pulses, plus a registered held level. Sits between the input conditioning stage and the game controller (jump/duck logic). Hold and repeat durations are counted in game ticks (frame strobes), not clock cycles, so timing tracks game speed.

## Interface
- HOLD_TICKS, 32, tick_en strobes in PRESSED before long_press fires; legal range 1 to 2^CNT_W.
- REPEAT_TICKS, 8, tick_en strobes between repeat_pulse events in LONG; legal range 1 to 2^CNT_W.
- CNT_W, 6, tick counter width; must hold max(HOLD_TICKS, REPEAT_TICKS)-1.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_en  in  1  one-cycle game tick strobe, synchronous to clk.
- btn_level  in  1  debounced button level, synchronous to clk; 1 = pressed.
- press  out  1  one-cycle pulse: new press detected.
- release  out  1  one-cycle pulse: button released.
- long_press  out  1  one-cycle pulse: hold reached HOLD_TICKS.
- repeat_pulse  out  1  one-cycle pulse: every REPEAT_TICKS while in LONG.
- held  out  1  level, 1 whenever state != IDLE.

## Operation
- States: IDLE, PRESSED, LONG. Counter cnt, CNT_W bits.
- IDLE: btn_level=1 -> PRESSED, cnt<=0, press<=1. Else stay. tick_en ignored.
- PRESSED: btn_level=0 -> IDLE, release<=1, cnt<=0. Else if tick_en: cnt==HOLD_TICKS-1 -> LONG, cnt<=0, long_press<=1; otherwise cnt<=cnt+1.
- LONG: btn_level=0 -> IDLE, release<=1, cnt<=0. Else if tick_en: cnt==REPEAT_TICKS-1 -> cnt<=0, repeat_pulse<=1; otherwise cnt<=cnt+1.
- Priority: release beats tick in the same cycle; no long_press/repeat_pulse on a release cycle.
- cnt never wraps: cleared on every transition and on reaching terminal value.
- At most one of press/release/long_press/repeat_pulse is high in any cycle.
- All pulse outputs are 0 in every cycle not named above.

## Timing
- Reset: state IDLE, cnt 0, press/release/long_press/repeat_pulse/held all 0, asynchronously on rst_n low.
- All outputs registered; event latency 1 cycle from the sampling edge.
- press high in cycle N+1 when btn_level first sampled 1 at edge N; held high from N+1.
- tick_en at edge N (IDLE) does not count toward HOLD_TICKS.
- long_press high one cycle after the HOLD_TICKS-th tick_en sampled in PRESSED.
- repeat_pulse high one cycle after every REPEAT_TICKS-th tick_en in LONG.
- release and held falling both occur in cycle N+1 after btn_level sampled 0 at edge N.
- HOLD_TICKS=1: long_press on first tick after press. REPEAT_TICKS=1: repeat_pulse on every tick in LONG.
- Reset mid-hold: all state lost; if btn_level still 1 after rst_n deasserts, a fresh press fires on the first clock edge.
- Back-to-back: release at N+1 then btn_level=1 sampled at N+1 gives press at N+2.

## Structure
- Shared package, common to the input-path blocks: state enum type (IDLE/PRESSED/LONG, 2 bits) and default constants for HOLD_TICKS and REPEAT_TICKS.
- Single module; no sub-module. Counter and FSM in one sequential process; next-state logic combinational.

## Test plan
- Use HOLD_TICKS=4, REPEAT_TICKS=2, tick_en every 3 cycles unless stated.
- Reset with btn_level=0: all outputs 0. Hold rst_n low while toggling btn_level: outputs stay 0.
- Short tap: btn_level high 5 cycles, no ticks -> press once at cycle+1, release once at cycle+1 after fall. No long_press.
- Long hold, 10 ticks: press; long_press after 4th tick; repeat_pulse after ticks 6, 8, 10; release on fall. held high throughout.
- btn_level falls in the same cycle as the 4th tick: release only, no long_press, state IDLE.
- rst_n pulsed low mid-LONG with btn_level=1: outputs 0 immediately, then press on first edge after deassert.
- Release then immediate re-press (btn_level 0 for one cycle): release at N+1, press at N+2, cnt restarts from 0.
